reorder_buffer: RTL

- Circular reorder buffer between dispatch/rename and architectural commit.
- Allocates an in-order tag (ROBNum) per dispatched instruction; the tag travels with the instruction through the unified issue queue.
- Collects out-of-order results from the three functional units (ALU0, ALU1, ALU2/mem).
- Retires up to two completed instructions per cycle, in program order, producing ARF writes and physical-register frees; also answers source-operand readiness queries for dispatch.

---
 rtl/reorder_buffer_if.sv | 79 +++++++
 rtl/reorder_buffer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_if.sv
// Dispatch / completion / retire bundle of the reorder buffer.
// master: the pipeline side driving dispatch, completion and queries.
// slave : the reorder buffer itself.
interface reorder_buffer_if #(
    parameter int PTR_W = 6
);
    // Dispatch / allocation
    logic              alloc_valid_in;
    logic [31:0]       PC_in;
    logic              alloc_hasDest_in;
    logic [4:0]        alloc_archReg_in;
    logic [5:0]        alloc_destReg_p_in;
    logic [5:0]        alloc_oldDestReg_p_in;
    logic [PTR_W-1:0]  alloc_ROBNum_out;
    logic              stall_out;

    // Source-operand readiness queries
    logic [5:0]        srcReg1_p_in;
    logic [5:0]        srcReg2_p_in;
    logic              srcReg1_ready_out;
    logic              srcReg2_ready_out;

    // Functional-unit completions
    logic              cmpl_valid0;
    logic              cmpl_valid1;
    logic              cmpl_valid2;
    logic [PTR_W-1:0]  cmpl_ROBNum0;
    logic [PTR_W-1:0]  cmpl_ROBNum1;
    logic [PTR_W-1:0]  cmpl_ROBNum2;
    logic [31:0]       cmpl_data0;
    logic [31:0]       cmpl_data1;
    logic [31:0]       cmpl_data2;

    // Retire slots
    logic              retire0_valid_out;
    logic [4:0]        retire0_archReg_out;
    logic [31:0]       retire0_data_out;
    logic              retire0_hasDest_out;
    logic [5:0]        retire0_freeReg_out;
    logic [31:0]       retire0_PC_out;
    logic              retire1_valid_out;
    logic [4:0]        retire1_archReg_out;
    logic [31:0]       retire1_data_out;
    logic              retire1_hasDest_out;
    logic [5:0]        retire1_freeReg_out;
    logic [31:0]       retire1_PC_out;

    logic [PTR_W:0]    count_out;

    modport master (
        output alloc_valid_in, PC_in, alloc_hasDest_in, alloc_archReg_in,
               alloc_destReg_p_in, alloc_oldDestReg_p_in,
               srcReg1_p_in, srcReg2_p_in,
               cmpl_valid0, cmpl_valid1, cmpl_valid2,
               cmpl_ROBNum0, cmpl_ROBNum1, cmpl_ROBNum2,
               cmpl_data0, cmpl_data1, cmpl_data2,
        input  alloc_ROBNum_out, stall_out, srcReg1_ready_out, srcReg2_ready_out,
               retire0_valid_out, retire0_archReg_out, retire0_data_out,
               retire0_hasDest_out, retire0_freeReg_out, retire0_PC_out,
               retire1_valid_out, retire1_archReg_out, retire1_data_out,
               retire1_hasDest_out, retire1_freeReg_out, retire1_PC_out,
               count_out
    );

    modport slave (
        input  alloc_valid_in, PC_in, alloc_hasDest_in, alloc_archReg_in,
               alloc_destReg_p_in, alloc_oldDestReg_p_in,
               srcReg1_p_in, srcReg2_p_in,
               cmpl_valid0, cmpl_valid1, cmpl_valid2,
               cmpl_ROBNum0, cmpl_ROBNum1, cmpl_ROBNum2,
               cmpl_data0, cmpl_data1, cmpl_data2,
        output alloc_ROBNum_out, stall_out, srcReg1_ready_out, srcReg2_ready_out,
               retire0_valid_out, retire0_archReg_out, retire0_data_out,
               retire0_hasDest_out, retire0_freeReg_out, retire0_PC_out,
               retire1_valid_out, retire1_archReg_out, retire1_data_out,
               retire1_hasDest_out, retire1_freeReg_out, retire1_PC_out,
               count_out
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order tag allocation, out-of-order completion
// from three functional units, in-order retire of up to two entries per cycle,
// and source-readiness answers for dispatch.
// Optional feature macro: ROB_FLUSH_EN adds flush_in (clears the whole buffer).
module reorder_buffer #(
    parameter int DEPTH = 64,
    parameter int PTR_W = 6
) (
    input  logic           clk,
    input  logic           rstn,
`ifdef ROB_FLUSH_EN
    input  logic           flush_in,
`endif
    reorder_buffer_if.slave rob
);

    // Pointers and occupancy
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] head_p1;
    logic [PTR_W:0]   count_q, count_d;
    logic             stall_q, stall_d;

    // Per-cycle handshake decisions
    logic             alloc_accept;
    logic             retire0;
    logic             retire1;
    logic [1:0]       n_retire;

    // Entry state exported from the per-entry generate blocks
    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_cmpl;
    logic [DEPTH-1:0] busy1;
    logic [DEPTH-1:0] busy2;
    logic             ent_hd   [DEPTH];
    logic [4:0]       ent_arch [DEPTH];
    logic [5:0]       ent_old  [DEPTH];
    logic [31:0]      ent_pc   [DEPTH];
    logic [31:0]      ent_data [DEPTH];

    // Registered retire slots
    logic             r0_valid_q, r0_valid_d;
    logic [4:0]       r0_arch_q,  r0_arch_d;
    logic [31:0]      r0_data_q,  r0_data_d;
    logic             r0_hd_q,    r0_hd_d;
    logic [5:0]       r0_free_q,  r0_free_d;
    logic [31:0]      r0_pc_q,    r0_pc_d;
    logic             r1_valid_q, r1_valid_d;
    logic [4:0]       r1_arch_q,  r1_arch_d;
    logic [31:0]      r1_data_q,  r1_data_d;
    logic             r1_hd_q,    r1_hd_d;
    logic [5:0]       r1_free_q,  r1_free_d;
    logic [31:0]      r1_pc_q,    r1_pc_d;

    assign head_p1 = head_q + PTR_W'(1);

    // Decide which allocation and retires happen at the coming edge.
    always_comb begin
        alloc_accept = rob.alloc_valid_in && !stall_q;
        retire0      = ent_valid[head_q] && ent_cmpl[head_q];
        retire1      = retire0 && ent_valid[head_p1] && ent_cmpl[head_p1];
`ifdef ROB_FLUSH_EN
        if (flush_in) begin
            alloc_accept = 1'b0;
            retire0      = 1'b0;
            retire1      = 1'b0;
        end
`endif
        n_retire = {1'b0, retire0} + {1'b0, retire1};
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam logic [PTR_W-1:0] TAG = PTR_W'(gi);

            logic        valid_q, valid_d;
            logic        cmpl_q,  cmpl_d;
            logic        hd_q,    hd_d;
            logic [4:0]  arch_q,  arch_d;
            logic [5:0]  dest_q,  dest_d;
            logic [5:0]  old_q,   old_d;
            logic [31:0] pc_q,    pc_d;
            logic [31:0] data_q,  data_d;
            logic        alloc_hit;
            logic        retire_hit;

            // Entry next state: completion (lowest port first), then retire, then allocation.
            always_comb begin
                valid_d    = valid_q;
                cmpl_d     = cmpl_q;
                hd_d       = hd_q;
                arch_d     = arch_q;
                dest_d     = dest_q;
                old_d      = old_q;
                pc_d       = pc_q;
                data_d     = data_q;
                alloc_hit  = alloc_accept && (tail_q == TAG);
                retire_hit = (retire0 && (head_q == TAG)) || (retire1 && (head_p1 == TAG));

                if (valid_q) begin
                    if (rob.cmpl_valid0 && (rob.cmpl_ROBNum0 == TAG)) begin
                        cmpl_d = 1'b1;
                        data_d = rob.cmpl_data0;
                    end else if (rob.cmpl_valid1 && (rob.cmpl_ROBNum1 == TAG)) begin
                        cmpl_d = 1'b1;
                        data_d = rob.cmpl_data1;
                    end else if (rob.cmpl_valid2 && (rob.cmpl_ROBNum2 == TAG)) begin
                        cmpl_d = 1'b1;
                        data_d = rob.cmpl_data2;
                    end
                end

                if (retire_hit) begin
                    valid_d = 1'b0;
                    cmpl_d  = 1'b0;
                end

                if (alloc_hit) begin
                    valid_d = 1'b1;
                    cmpl_d  = 1'b0;
                    hd_d    = rob.alloc_hasDest_in;
                    arch_d  = rob.alloc_archReg_in;
                    dest_d  = rob.alloc_destReg_p_in;
                    old_d   = rob.alloc_oldDestReg_p_in;
                    pc_d    = rob.PC_in;
                end

`ifdef ROB_FLUSH_EN
                if (flush_in) begin
                    valid_d = 1'b0;
                    cmpl_d  = 1'b0;
                end
`endif
            end

            // Entry status bits; cleared by reset.
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    valid_q <= 1'b0;
                    cmpl_q  <= 1'b0;
                end else begin
                    valid_q <= valid_d;
                    cmpl_q  <= cmpl_d;
                end
            end

            // Entry payload; only meaningful while valid, so never reset.
            always_ff @(posedge clk) begin
                hd_q   <= hd_d;
                arch_q <= arch_d;
                dest_q <= dest_d;
                old_q  <= old_d;
                pc_q   <= pc_d;
                data_q <= data_d;
            end

            assign ent_valid[gi] = valid_q;
            assign ent_cmpl[gi]  = cmpl_q;
            assign ent_hd[gi]    = hd_q;
            assign ent_arch[gi]  = arch_q;
            assign ent_old[gi]   = old_q;
            assign ent_pc[gi]    = pc_q;
            assign ent_data[gi]  = data_q;
            // An in-flight producer of the queried register makes it not ready.
            assign busy1[gi] = valid_q && !cmpl_q && hd_q && (dest_q == rob.srcReg1_p_in);
            assign busy2[gi] = valid_q && !cmpl_q && hd_q && (dest_q == rob.srcReg2_p_in);
        end
    endgenerate

    // Pointer, occupancy and full-flag update.
    always_comb begin
        head_d  = head_q + PTR_W'(n_retire);
        tail_d  = tail_q + PTR_W'(alloc_accept);
        count_d = count_q + (PTR_W+1)'(alloc_accept) - (PTR_W+1)'(n_retire);
        stall_d = (count_d == (PTR_W+1)'(DEPTH));
`ifdef ROB_FLUSH_EN
        if (flush_in) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            stall_d = 1'b0;
        end
`endif
    end

    // Retire slot contents; fields hold their last value when nothing retires.
    always_comb begin
        r0_valid_d = retire0;
        r0_arch_d  = r0_arch_q;
        r0_data_d  = r0_data_q;
        r0_hd_d    = r0_hd_q;
        r0_free_d  = r0_free_q;
        r0_pc_d    = r0_pc_q;
        r1_valid_d = retire1;
        r1_arch_d  = r1_arch_q;
        r1_data_d  = r1_data_q;
        r1_hd_d    = r1_hd_q;
        r1_free_d  = r1_free_q;
        r1_pc_d    = r1_pc_q;
        if (retire0) begin
            r0_arch_d = ent_arch[head_q];
            r0_data_d = ent_data[head_q];
            r0_hd_d   = ent_hd[head_q];
            r0_free_d = ent_old[head_q];
            r0_pc_d   = ent_pc[head_q];
        end
        if (retire1) begin
            r1_arch_d = ent_arch[head_p1];
            r1_data_d = ent_data[head_p1];
            r1_hd_d   = ent_hd[head_p1];
            r1_free_d = ent_old[head_p1];
            r1_pc_d   = ent_pc[head_p1];
        end
    end

    // Control and retire registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            stall_q    <= 1'b0;
            r0_valid_q <= 1'b0;
            r0_arch_q  <= '0;
            r0_data_q  <= '0;
            r0_hd_q    <= 1'b0;
            r0_free_q  <= '0;
            r0_pc_q    <= '0;
            r1_valid_q <= 1'b0;
            r1_arch_q  <= '0;
            r1_data_q  <= '0;
            r1_hd_q    <= 1'b0;
            r1_free_q  <= '0;
            r1_pc_q    <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            stall_q    <= stall_d;
            r0_valid_q <= r0_valid_d;
            r0_arch_q  <= r0_arch_d;
            r0_data_q  <= r0_data_d;
            r0_hd_q    <= r0_hd_d;
            r0_free_q  <= r0_free_d;
            r0_pc_q    <= r0_pc_d;
            r1_valid_q <= r1_valid_d;
            r1_arch_q  <= r1_arch_d;
            r1_data_q  <= r1_data_d;
            r1_hd_q    <= r1_hd_d;
            r1_free_q  <= r1_free_d;
            r1_pc_q    <= r1_pc_d;
        end
    end

    assign rob.alloc_ROBNum_out    = tail_q;
    assign rob.stall_out           = stall_q;
    assign rob.count_out           = count_q;
    assign rob.srcReg1_ready_out   = (rob.srcReg1_p_in == 6'd0) || !(|busy1);
    assign rob.srcReg2_ready_out   = (rob.srcReg2_p_in == 6'd0) || !(|busy2);
    assign rob.retire0_valid_out   = r0_valid_q;
    assign rob.retire0_archReg_out = r0_arch_q;
    assign rob.retire0_data_out    = r0_data_q;
    assign rob.retire0_hasDest_out = r0_hd_q;
    assign rob.retire0_freeReg_out = r0_free_q;
    assign rob.retire0_PC_out      = r0_pc_q;
    assign rob.retire1_valid_out   = r1_valid_q;
    assign rob.retire1_archReg_out = r1_arch_q;
    assign rob.retire1_data_out    = r1_data_q;
    assign rob.retire1_hasDest_out = r1_hd_q;
    assign rob.retire1_freeReg_out = r1_free_q;
    assign rob.retire1_PC_out      = r1_pc_q;

endmodule
